// File: rtl/tick_rec_player_pkg.sv
// Shared types and helpers for the tick_rec_player timebase / sample recorder.
// Holds the FSM state encoding and the prescaler width helper.
package tick_rec_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REC  = 2'b01,
    ST_PLAY = 2'b10
  } state_t;

  // The prescaler counts 0..div-1, so it needs clog2(div) bits; a divide of 1 still gets one bit.
  function automatic int unsigned div_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for one raw button.
// The pulse is high for exactly one cycle per press, however long the button is held.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      prev <= sync;
    end
  end

  assign pulse = sync & ~prev;

endmodule

// File: rtl/tick_rec_player.sv
// Prescaled counter with a small sample memory that can be written manually,
// filled by a timed recording, and replayed in an endless loop one slot per tick.
module tick_rec_player
  import tick_rec_player_pkg::*;
#(
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              store,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] man_addr,
  output logic              tick,
  output logic [CNT_W-1:0]  cnt_val,
  output logic [CNT_W-1:0]  man_data,
  output logic [CNT_W-1:0]  play_data,
  output logic [ADDR_W-1:0] play_addr,
  output logic [ADDR_W:0]   rec_len,
  output logic [1:0]        state
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned DIV_W = div_width(TICK_DIV);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   LEN_LAST = (ADDR_W + 1)'(DEPTH - 1);

  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic store_ev;
  logic rec_ev;
  logic play_ev;
  logic stop_ev;

  state_t            cur_state;
  state_t            state_nxt;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rec_init;
  logic              rec_adv;
  logic              play_init;
  logic              play_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // clr beats tick but leaves the prescaler phase untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_val <= '0;
    end else if (clr) begin
      cnt_val <= '0;
    end else if (tick) begin
      cnt_val <= cnt_val + CNT_ONE;
    end
  end

  btn_sync_edge u_store_sync (.clk(clk), .rst_n(rst_n), .raw(store),      .pulse(store_ev));
  btn_sync_edge u_rec_sync   (.clk(clk), .rst_n(rst_n), .raw(rec_start),  .pulse(rec_ev));
  btn_sync_edge u_play_sync  (.clk(clk), .rst_n(rst_n), .raw(play_start), .pulse(play_ev));
  btn_sync_edge u_stop_sync  (.clk(clk), .rst_n(rst_n), .raw(stop),       .pulse(stop_ev));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = cur_state;
    wr_en     = 1'b0;
    wr_addr   = man_addr;
    rec_init  = 1'b0;
    rec_adv   = 1'b0;
    play_init = 1'b0;
    play_adv  = 1'b0;
    unique case (cur_state)
      ST_IDLE: begin
        if (store_ev) begin
          wr_en = 1'b1;
        end
        if (rec_ev) begin
          state_nxt = ST_REC;
          rec_init  = 1'b1;
        end else if (play_ev && (rec_len != '0)) begin
          state_nxt = ST_PLAY;
          play_init = 1'b1;
        end
      end
      ST_REC: begin
        // A stop arriving with a tick suppresses that tick's write.
        if (stop_ev) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          wr_en   = 1'b1;
          wr_addr = wr_ptr;
          rec_adv = 1'b1;
          if (rec_len == LEN_LAST) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_PLAY: begin
        if (stop_ev) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          play_adv = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= cnt_val;
    end
  end

  assign man_data = mem[man_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rec_len <= '0;
    end else if (rec_init) begin
      wr_ptr  <= '0;
      rec_len <= '0;
    end else if (rec_adv) begin
      wr_ptr  <= wr_ptr + PTR_ONE;
      rec_len <= rec_len + LEN_ONE;
    end
  end

  // Playback loops over the recorded slots only, not the whole memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      play_data <= '0;
      play_addr <= '0;
    end else if (play_init) begin
      rd_ptr <= '0;
    end else if (play_adv) begin
      play_data <= mem[rd_ptr];
      play_addr <= rd_ptr;
      rd_ptr    <= ({1'b0, rd_ptr} == (rec_len - LEN_ONE)) ? '0 : (rd_ptr + PTR_ONE);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_tick_rec_player.sv
// Bench for tick_rec_player: directed vectors with hand-derived expectations,
// corner-case sequences, and randomised buttons compared against a cycle model.
module tb_tick_rec_player;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 4;
  localparam int ADDR_W   = 3;
  localparam int DEPTH    = 8;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       store;
  logic       rec_start;
  logic       play_start;
  logic       stop;
  logic [2:0] man_addr;
  logic       tick;
  logic [3:0] cnt_val;
  logic [3:0] man_data;
  logic [3:0] play_data;
  logic [2:0] play_addr;
  logic [3:0] rec_len;
  logic [1:0] state;

  int checks;
  int fails;

  int m_ncyc;
  int m_cnt;
  int m_mem [DEPTH];
  int m_mode;
  int m_wr;
  int m_len;
  int m_rd;
  int m_pd;
  int m_pa;
  bit m_wrote;
  bit m_played;
  bit hist [4][3];

  typedef struct {
    int clr, store, rec, play, stop, addr, cycles;
    int exp_cnt, exp_state, exp_len, exp_man, exp_pd, exp_pa;
  } vec_t;

  vec_t vecs [10];

  tick_rec_player #(
    .TICK_DIV(TICK_DIV),
    .CNT_W(CNT_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .store(store),
    .rec_start(rec_start),
    .play_start(play_start),
    .stop(stop),
    .man_addr(man_addr),
    .tick(tick),
    .cnt_val(cnt_val),
    .man_data(man_data),
    .play_data(play_data),
    .play_addr(play_addr),
    .rec_len(rec_len),
    .state(state)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  function automatic void model_reset();
    m_ncyc = 0;
    m_cnt  = 0;
    m_mode = 0;
    m_wr   = 0;
    m_len  = 0;
    m_rd   = 0;
    m_pd   = 0;
    m_pa   = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 3; k++) hist[b][k] = 1'b0;
  endfunction

  // A press sampled at edge n-2 that was low at edge n-3 acts at edge n.
  function automatic void model_edge();
    bit raw [4];
    bit ev [4];
    bit tick_now;
    int old_cnt;
    raw[0] = store;
    raw[1] = rec_start;
    raw[2] = play_start;
    raw[3] = stop;
    tick_now = ((m_ncyc % TICK_DIV) == TICK_DIV - 1);
    for (int b = 0; b < 4; b++) begin
      ev[b] = hist[b][1] && !hist[b][2];
      hist[b][2] = hist[b][1];
      hist[b][1] = hist[b][0];
      hist[b][0] = raw[b];
    end
    m_wrote  = 1'b0;
    m_played = 1'b0;
    old_cnt  = m_cnt;
    case (m_mode)
      0: begin
        if (ev[0]) m_mem[man_addr] = old_cnt;
        if (ev[1]) begin
          m_mode = 1;
          m_wr   = 0;
          m_len  = 0;
        end else if (ev[2] && m_len != 0) begin
          m_mode = 2;
          m_rd   = 0;
        end
      end
      1: begin
        if (ev[3]) begin
          m_mode = 0;
        end else if (tick_now) begin
          m_mem[m_wr] = old_cnt;
          m_wr  = (m_wr + 1) % DEPTH;
          m_len = m_len + 1;
          m_wrote = 1'b1;
          if (m_len == DEPTH) m_mode = 0;
        end
      end
      default: begin
        if (ev[3]) begin
          m_mode = 0;
        end else if (tick_now) begin
          m_pd = m_mem[m_rd];
          m_pa = m_rd;
          m_rd = (m_rd + 1) % m_len;
          m_played = 1'b1;
        end
      end
    endcase
    if (clr) m_cnt = 0;
    else if (tick_now) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    m_ncyc++;
  endfunction

  task automatic check_all();
    checkOutput("tick", int'(tick), int'((m_ncyc % TICK_DIV) == TICK_DIV - 1));
    checkOutput("cnt_val", int'(cnt_val), m_cnt);
    checkOutput("man_data", int'(man_data), m_mem[man_addr]);
    checkOutput("play_data", int'(play_data), m_pd);
    checkOutput("play_addr", int'(play_addr), m_pa);
    checkOutput("rec_len", int'(rec_len), m_len);
    checkOutput("state", int'(state), m_mode);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic clear_inputs();
    clr        = 1'b0;
    store      = 1'b0;
    rec_start  = 1'b0;
    play_start = 1'b0;
    stop       = 1'b0;
  endtask

  // Asserts reset between edges and verifies everything clears before the next edge.
  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_tick", int'(tick), 0);
    checkOutput("rst_cnt_val", int'(cnt_val), 0);
    checkOutput("rst_play_data", int'(play_data), 0);
    checkOutput("rst_play_addr", int'(play_addr), 0);
    checkOutput("rst_rec_len", int'(rec_len), 0);
    checkOutput("rst_state", int'(state), 0);
    for (int a = 0; a < DEPTH; a++) begin
      man_addr = 3'(a);
      #1;
      checkOutput($sformatf("rst_mem%0d", a), int'(man_data), 0);
    end
    man_addr = 3'd0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    clr        = v.clr[0];
    store      = v.store[0];
    rec_start  = v.rec[0];
    play_start = v.play[0];
    stop       = v.stop[0];
    man_addr   = 3'(v.addr);
    repeat (v.cycles) step();
    checkOutput($sformatf("v%0d_cnt", idx), int'(cnt_val), v.exp_cnt);
    checkOutput($sformatf("v%0d_state", idx), int'(state), v.exp_state);
    checkOutput($sformatf("v%0d_len", idx), int'(rec_len), v.exp_len);
    checkOutput($sformatf("v%0d_man", idx), int'(man_data), v.exp_man);
    checkOutput($sformatf("v%0d_pd", idx), int'(play_data), v.exp_pd);
    checkOutput($sformatf("v%0d_pa", idx), int'(play_addr), v.exp_pa);
  endtask

  initial begin
    int k;
    int n;
    checks = 0;
    fails  = 0;
    man_addr = 3'd0;
    rst_n = 1'b0;
    clear_inputs();
    model_reset();

    //            clr st rec pl sp adr cyc  cnt st len man pd pa
    vecs[0] = '{0, 0, 0, 0, 0, 0, 20,  5, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 0, 0, 0, 2, 40, 15, 0, 0, 5, 0, 0};
    vecs[2] = '{0, 0, 0, 0, 0, 3,  2, 15, 0, 0, 0, 0, 0};
    vecs[3] = '{1, 0, 0, 0, 0, 2,  2,  0, 0, 0, 5, 0, 0};
    vecs[4] = '{0, 0, 1, 0, 0, 2,  1,  0, 0, 0, 5, 0, 0};
    vecs[5] = '{0, 0, 0, 0, 0, 5, 31,  8, 0, 8, 5, 0, 0};
    vecs[6] = '{0, 0, 0, 1, 0, 7,  1,  8, 0, 8, 7, 0, 0};
    vecs[7] = '{0, 0, 0, 0, 0, 7,  8, 10, 2, 8, 7, 1, 1};
    vecs[8] = '{0, 0, 0, 0, 1, 7,  1, 10, 2, 8, 7, 1, 1};
    vecs[9] = '{0, 0, 0, 0, 0, 2,  6, 12, 0, 8, 2, 1, 1};

    #5;
    apply_reset();

    for (int i = 0; i < 10; i++) applyStimulus(i, vecs[i]);
    clear_inputs();

    $display("[TB] short recording then looping playback");
    clr = 1'b1;
    rec_start = 1'b1;
    step();
    rec_start = 1'b0;
    for (k = 0; k < 20 && m_mode != 1; k++) step();
    checkOutput("rec_entered", int'(state), 1);
    clr = 1'b0;
    n = 0;
    for (k = 0; k < 40 && n < 3; k++) begin
      step();
      if (m_wrote) n++;
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (5) step();
    checkOutput("rec3_len", int'(rec_len), 3);
    checkOutput("rec3_state", int'(state), 0);

    play_start = 1'b1;
    step();
    play_start = 1'b0;
    n = 0;
    for (k = 0; k < 80 && n < 6; k++) begin
      step();
      if (m_played) begin
        checkOutput("play_seq_data", int'(play_data), n % 3);
        checkOutput("play_seq_addr", int'(play_addr), n % 3);
        n++;
      end
    end
    checkOutput("play_seq_count", n, 6);
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (6) step();
    checkOutput("stop_state", int'(state), 0);
    checkOutput("stop_hold_data", int'(play_data), 2);
    checkOutput("stop_hold_addr", int'(play_addr), 2);

    $display("[TB] asynchronous reset during playback");
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    n = 0;
    for (k = 0; k < 40 && n < 2; k++) begin
      step();
      if (m_played) n++;
    end
    checkOutput("pre_reset_state", int'(state), 2);
    apply_reset();

    $display("[TB] play with empty recording, simultaneous rec and play");
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    repeat (6) step();
    checkOutput("empty_play_state", int'(state), 0);
    rec_start  = 1'b1;
    play_start = 1'b1;
    step();
    rec_start  = 1'b0;
    play_start = 1'b0;
    repeat (4) step();
    checkOutput("rec_wins_state", int'(state), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (4) step();
    checkOutput("rec_stopped_state", int'(state), 0);

    $display("[TB] randomised buttons against model");
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) store = ~store;
      if ($urandom_range(0, 7) == 0) rec_start = ~rec_start;
      if ($urandom_range(0, 5) == 0) play_start = ~play_start;
      if ($urandom_range(0, 11) == 0) stop = ~stop;
      clr = ($urandom_range(0, 19) == 0);
      man_addr = 3'($urandom_range(0, 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/tick_rec_player.md
Name: tick_rec_player

Overview:
- Parametrised timebase, counter and sample-memory block for the board display path.
- A prescaler generates a periodic tick that advances a free-running counter.
- Counter values are stored into an internal memory in two ways: manually at a switch-selected address, or automatically into consecutive slots during a timed recording.
- A looping playback engine replays the recording one slot per tick. Downstream 7-segment transcoders consume `cnt_val`, `man_data` and `play_data`.

Parameters:
- TICK_DIV, 500000: clock cycles per tick. Must be ≥1; a value of 1 gives a tick every cycle.
- CNT_W, 4: counter and memory data width.
- ADDR_W, 3: memory address width. DEPTH = 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous counter clear, level, already synchronous.
- store  in  1  manual-store button, raw.
- rec_start  in  1  record button, raw.
- play_start  in  1  playback button, raw.
- stop  in  1  stop button, raw.
- man_addr  in  ADDR_W  manual store/read address (switches).
- tick  out  1  one-cycle prescaler pulse.
- cnt_val  out  CNT_W  counter value.
- man_data  out  CNT_W  memory contents at man_addr, combinational read.
- play_data  out  CNT_W  current playback sample, registered.
- play_addr  out  ADDR_W  slot index of play_data.
- rec_len  out  ADDR_W+1  number of valid recorded slots.
- state  out  2  00 IDLE, 01 REC, 10 PLAY.

Behaviour:

Reset (rst_n low, asynchronous):
- All registers clear: prescaler, counter, memory, pointers, rec_len, play_data, play_addr, synchroniser/edge flops.
- tick = 0, state = IDLE.

Prescaler:
- div_cnt runs 0..TICK_DIV-1 and wraps.
- tick = 1 exactly in the cycle where div_cnt == TICK_DIV-1.
- Period is TICK_DIV cycles.

Counter:
- On tick, cnt_val increments, wrapping from 2**CNT_W-1 to 0.
- clr takes priority over tick and forces 0.
- The prescaler is unaffected by clr.

Buttons (store, rec_start, play_start, stop):
- Each passes through a 2-flop synchroniser and a rising-edge detector.
- One event pulse is produced per press, high for 1 cycle.
- Registered effects appear on the 3rd rising clk edge after the input is first sampled high.
- A held button produces no repeat events.

FSM:
- IDLE:
  - store event: mem[man_addr] <= cnt_val (pre-update value at that edge).
  - rec_start event: go to REC; wr_ptr = 0, rec_len = 0.
  - play_start event with rec_len != 0: go to PLAY; rd_ptr = 0.
  - play_start event with rec_len == 0: ignored.
  - rec_start and play_start in the same cycle: rec_start wins.
- REC:
  - On each tick: mem[wr_ptr] <= cnt_val (old value, same edge as the counter increment); wr_ptr++, rec_len++.
  - The write that brings rec_len to DEPTH also returns the FSM to IDLE.
  - stop event: go to IDLE; rec_len is retained.
  - stop together with tick: no write occurs.
  - store, rec_start and play_start are ignored.
- PLAY:
  - On each tick: play_data <= mem[rd_ptr], play_addr <= rd_ptr.
  - rd_ptr then advances, wrapping to 0 after rec_len-1 (endless loop).
  - stop event: go to IDLE; play_data and play_addr hold their last values.
  - stop wins over a simultaneous tick.
  - Other events are ignored.

Memory:
- DEPTH × CNT_W registers, single write port.
- man_data is a combinational read of man_addr and is valid in every state.
- clr never alters memory contents.

Decomposition:
- Shared package contents:
  - state encoding constants ST_IDLE/ST_REC/ST_PLAY.
  - helper function for the prescaler width, clog2(TICK_DIV).
- Sub-module btn_sync_edge: 2-flop synchroniser plus edge detector, with clk and rst_n. Instantiated four times.
- The prescaler, counter, memory and FSM stay inline.

Test Plan:
All scenarios use TICK_DIV=4, CNT_W=4, ADDR_W=3.
1. Release reset, run 64 cycles → tick every 4th cycle; cnt_val wraps 15→0 after 16 ticks; all outputs 0 immediately after reset.
2. Counter at 5, man_addr=2, pulse store → mem[2]=5; man_data=5 with man_addr=2, man_data=0 with man_addr=3. Hold store high 40 cycles → only one write.
3. rec_start with cnt_val=0, run 8 ticks → mem[0..7]=0..7, rec_len=8, state returns to IDLE automatically; a 9th tick writes nothing.
4. rec_start, 3 ticks, stop → rec_len=3. Then play_start → play_data sequence 0,1,2,0,1,2 on successive ticks with play_addr 0,1,2,0,… Stop → values hold, state=IDLE.
5. rec_len=0, press play_start → state stays IDLE. Press rec_start and play_start on the same cycle → state=REC.
6. Assert rst_n low mid-PLAY, asynchronously between clock edges → every output 0 and state IDLE before the next clk edge; memory cleared.
